// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared controller state type and default register index width
package pipe_ctrl_pkg;
  localparam int DEF_REG_ADDR_W = 5;
  typedef enum logic {RUN, MD_WAIT} ctrl_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator between the EX load and the ID sources
module hazard_detect import pipe_ctrl_pkg::*; #(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  output logic                  load_use
);
  assign load_use = ex_memread && ex_rd != '0 &&
                    ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the 5-stage pipeline with stall counter and memory timeout
module pipe_hazard_ctrl import pipe_ctrl_pkg::*; #(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic                  ex_branch_taken,
  input  logic                  ex_md_op,
  input  logic                  md_done,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_flush,
  output logic                  md_start,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_count
);
  localparam int WW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  ctrl_state_t state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q;
  logic err_q, load_use, mem_stall, md_go, md_fin, wait_last;
  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hd (
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .load_use(load_use)
  );
  assign mem_stall = mem_req && !mem_ready && !err_q;
  assign md_go = state_q == MD_WAIT || ex_md_op;
  assign md_fin = state_q == MD_WAIT && md_done;
  assign wait_last = wait_q == WW'(MEM_TIMEOUT - 1);
  assign wait_d = (mem_stall && !wait_last) ? wait_q + 1'b1 : '0;
  assign state_d = mem_stall ? state_q : md_fin ? RUN : md_go ? MD_WAIT : RUN;
  assign mem_err = err_q;
  assign stall_count = cnt_q;
  always_comb begin
    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
    {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, md_start} = '0;
    if (rst) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
      if (mem_stall) begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en} = '0;
        mem_wb_flush = 1'b1;
      end else if (md_go) begin
        md_start = state_q == RUN;
        if (!md_fin) begin
          {pc_en, if_id_en, id_ex_en} = '0;
          ex_mem_flush = 1'b1;
        end
      end else if (ex_branch_taken) begin
        {if_id_flush, id_ex_flush} = 2'b11;
      end else if (load_use) begin
        {pc_en, if_id_en} = '0;
        id_ex_flush = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_q || (mem_stall && wait_last);
      if (!pc_en && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed stimulus with a behavioural model checked every cycle
module tb_pipe_hazard_ctrl;
  localparam int RW = 5;
  localparam int TO = 64;
  localparam int CW = 32;
  localparam logic [9:0] IDLE = 10'b11111_0000_0;
  localparam logic [9:0] LU   = 10'b00111_0100_0;
  localparam logic [9:0] BR   = 10'b11111_1100_0;
  localparam logic [9:0] MS   = 10'b00001_0001_0;
  localparam logic [9:0] MDW  = 10'b00011_0010_0;
  localparam logic [9:0] MDS  = 10'b00011_0010_1;
  logic clk = 1'b0, rst = 1'b0;
  logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_memread = 0, ex_branch_taken = 0;
  logic ex_md_op = 0, md_done = 0, mem_req = 0, mem_ready = 0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, md_start, mem_err;
  logic [CW-1:0] stall_count;
  logic [9:0] ctrl_vec;
  int errors = 0, checks = 0;
  bit m_md = 0, m_err = 0;
  int m_wait = 0;
  longint m_cnt = 0;
  pipe_hazard_ctrl #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .ex_md_op(ex_md_op), .md_done(md_done),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .if_id_en(if_id_en),
    .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .md_start(md_start), .mem_err(mem_err),
    .stall_count(stall_count)
  );
  assign ctrl_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, md_start};
  always #5 clk = ~clk;
  function automatic logic [9:0] model_ctrl();
    logic [4:0] en = '1;
    logic [3:0] fl = '0;
    logic st = 1'b0;
    if (!rst) return '0;
    if (mem_req && !mem_ready && !m_err) begin
      en = 5'b00001;
      fl = 4'b0001;
    end else if (m_md || ex_md_op) begin
      st = !m_md;
      if (!(m_md && md_done)) begin
        en = 5'b00011;
        fl = 4'b0010;
      end
    end else if (ex_branch_taken) begin
      fl = 4'b1100;
    end else if (ex_memread && ex_rd != 0 &&
                 ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2))) begin
      en = 5'b00111;
      fl = 4'b0100;
    end
    return {en, fl, st};
  endfunction
  always @(negedge clk) begin
    logic [9:0] exp_v;
    bit stall;
    exp_v = model_ctrl();
    checks += 3;
    if (ctrl_vec !== exp_v) begin
      errors++;
      $display("FAIL model_ctrl t=%0t got=%b exp=%b", $time, ctrl_vec, exp_v);
    end
    if (mem_err !== m_err) begin
      errors++;
      $display("FAIL model_err t=%0t got=%b exp=%b", $time, mem_err, m_err);
    end
    if (stall_count !== CW'(m_cnt)) begin
      errors++;
      $display("FAIL model_cnt t=%0t got=%0d exp=%0d", $time, stall_count, m_cnt);
    end
    if (!rst) begin
      m_md = 0; m_err = 0; m_wait = 0; m_cnt = 0;
    end else begin
      stall = mem_req && !mem_ready && !m_err;
      if (!exp_v[9] && m_cnt < (64'd1 << CW) - 1) m_cnt++;
      if (stall) begin
        m_wait++;
        if (m_wait == TO) begin
          m_err = 1;
          m_wait = 0;
        end
      end else m_wait = 0;
      if (!stall) m_md = m_md ? !md_done : ex_md_op;
    end
  end
  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp_v);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    {id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken, ex_md_op, md_done, mem_req, mem_ready} = '0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
  endtask
  initial begin
    int n, starts, pc_low, exf;
    repeat (3) step();
    #1 chk("rst_ctrl", 64'(ctrl_vec), 0);
    chk("rst_cnt", 64'(stall_count), 0);
    chk("rst_err", 64'(mem_err), 0);
    step(); rst = 1;
    #1 chk("idle_ctrl", 64'(ctrl_vec), 64'(IDLE));
    step(); ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    #1 chk("lu_ctrl", 64'(ctrl_vec), 64'(LU));
    step(); clear();
    #1 chk("lu_release", 64'(ctrl_vec), 64'(IDLE));
    chk("lu_cnt", 64'(stall_count), 1);
    step(); ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    #1 chk("lu_x0", 64'(ctrl_vec), 64'(IDLE));
    step(); ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; id_use_rs1 = 0;
    #1 chk("lu_rs2", 64'(ctrl_vec), 64'(LU));
    step(); id_use_rs2 = 0;
    #1 chk("lu_rs2_unused", 64'(ctrl_vec), 64'(IDLE));
    chk("lu_cnt2", 64'(stall_count), 2);
    step(); clear(); ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; ex_branch_taken = 1;
    #1 chk("br_ctrl", 64'(ctrl_vec), 64'(BR));
    step(); clear();
    #1 chk("br_cnt", 64'(stall_count), 2);
    starts = 0; pc_low = 0; exf = 0;
    for (int i = 0; i < 7; i++) begin
      step(); ex_md_op = 1; md_done = (i == 6);
      #1;
      starts += int'(md_start);
      pc_low += int'(!pc_en);
      exf += int'(ex_mem_flush);
      if (i == 6) chk("md_done_ctrl", 64'(ctrl_vec), 64'(IDLE));
    end
    chk("md_starts", 64'(starts), 1);
    chk("md_pc_low", 64'(pc_low), 6);
    chk("md_exf", 64'(exf), 6);
    step(); ex_md_op = 0;
    #1 chk("md_back_run", 64'(ctrl_vec), 64'(IDLE));
    chk("md_cnt", 64'(stall_count), 8);
    step(); clear();
    for (int i = 0; i < 3; i++) begin
      step(); mem_req = 1; mem_ready = 0;
      #1 chk("ms_ctrl", 64'(ctrl_vec), 64'(MS));
    end
    step(); mem_ready = 1;
    #1 chk("ms_release", 64'(ctrl_vec), 64'(IDLE));
    chk("ms_err", 64'(mem_err), 0);
    chk("ms_cnt", 64'(stall_count), 11);
    step(); mem_ready = 0;
    #1 n = 0;
    while (!pc_en && n < 100) begin
      n++;
      step(); #1;
    end
    chk("to_cycles", 64'(n), 64);
    chk("to_err", 64'(mem_err), 1);
    chk("to_cnt", 64'(stall_count), 75);
    step(); clear();
    #1 chk("err_sticky", 64'(mem_err), 1);
    step(); mem_req = 1;
    #1 chk("err_no_stall", 64'(ctrl_vec), 64'(IDLE));
    step(); clear(); ex_md_op = 1;
    step();
    #1 chk("md_wait", 64'(ctrl_vec), 64'(MDW));
    step(); rst = 0;
    #1 chk("rst_mid_ctrl", 64'(ctrl_vec), 0);
    step();
    #1 chk("rst_mid_cnt", 64'(stall_count), 0);
    chk("rst_mid_err", 64'(mem_err), 0);
    step(); rst = 1; ex_md_op = 0;
    #1 chk("post_rst_idle", 64'(ctrl_vec), 64'(IDLE));
    step(); ex_md_op = 1;
    #1 chk("md2_start", 64'(ctrl_vec), 64'(MDS));
    step(); mem_req = 1; mem_ready = 0;
    #1 chk("md_memstall", 64'(ctrl_vec), 64'(MS));
    step(); mem_req = 0; md_done = 1;
    #1 chk("md_mem_done", 64'(ctrl_vec), 64'(IDLE));
    step(); clear();
    #1 chk("final_idle", 64'(ctrl_vec), 64'(IDLE));
    chk("final_cnt", 64'(stall_count), 2);
    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
